// File: rtl/tx_word_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two word requesters,
// serialising each granted word LSB byte first over the tx_start / tx_done handshake.
module tx_word_arbiter #(
    parameter int N_BITS_DATA = 8,
    parameter int N_BYTES     = 4,
    parameter int N_BITS_TOUT = 4,
    parameter int TOUT_CYCLES = 15
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req0,
    input  logic [N_BITS_DATA*N_BYTES-1:0] word0,
    output logic                           ack0,
    input  logic                           req1,
    input  logic [N_BITS_DATA*N_BYTES-1:0] word1,
    output logic                           ack1,
    input  logic                           tx_done,
    output logic                           tx_start,
    output logic [N_BITS_DATA-1:0]         tx_data,
    output logic                           busy,
    output logic                           err
);

    localparam int WORD_W = N_BITS_DATA * N_BYTES;
    localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(N_BYTES - 1);
    localparam logic [N_BITS_TOUT-1:0] TOUT_LAST = N_BITS_TOUT'(TOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_BITS_TOUT-1:0] wd_q, wd_d;
    logic                   last_grant_q, last_grant_d;
    logic                   ack0_d, ack1_d, tx_start_d, busy_d, err_d;
    logic [N_BITS_DATA-1:0] tx_data_d;
    logic                   grant0, grant1;

    // On a tie the requester that was not granted last time wins.
    assign grant0 = req0 & (~req1 | last_grant_q);
    assign grant1 = req1 & ~grant0;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        wd_d         = wd_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data;
        err_d        = err;

        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    shift_d      = grant0 ? word0 : word1;
                    idx_d        = '0;
                    ack0_d       = grant0;
                    ack1_d       = grant1;
                    last_grant_d = grant1;
                    state_d      = START;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_done) begin
                    state_d = WAIT_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    // Transmitter never went busy: give up on the rest of this word.
                    if (wd_q == TOUT_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_done) state_d = NEXT;
            end
            NEXT: begin
                shift_d = shift_q >> N_BITS_DATA;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == START) begin
            tx_start_d = 1'b1;
            tx_data_d  = shift_d[N_BITS_DATA-1:0];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wd_q         <= '0;
            last_grant_q <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wd_q         <= wd_d;
            last_grant_q <= last_grant_d;
            ack0         <= ack0_d;
            ack1         <= ack1_d;
            tx_start     <= tx_start_d;
            tx_data      <= tx_data_d;
            busy         <= busy_d;
            err          <= err_d;
        end
    end

    // Word shift register is pure data; it is always reloaded before use.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Scoreboard bench for tx_word_arbiter: expected bytes and grant order are queued as
// stimulus is driven and popped as tx_start / ack pulses appear.
module tb_tx_word_arbiter;

    logic        clock, reset;
    logic        req0, req1, ack0, ack1;
    logic [31:0] word0, word1;
    logic        tx_done, tx_start, busy, err;
    logic [7:0]  tx_data;

    int          checks = 0;
    int          errors = 0;
    int          n_starts = 0;
    int          n_ack0 = 0;
    int          tx_cnt = 0;
    bit          tx_stuck = 0;
    logic        prev_ack0 = 0, prev_ack1 = 0;
    logic [7:0]  exp_bytes[$];
    int          exp_grants[$];

    tx_word_arbiter #(
        .N_BITS_DATA(8), .N_BYTES(4), .N_BITS_TOUT(4), .TOUT_CYCLES(15)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .word0(word0), .ack0(ack0),
        .req1(req1), .word1(word1), .ack1(ack1),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .err(err)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "simulation time limit");
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(w[8*i +: 8]);
    endtask

    // One cycle at the falling edge: scoreboard, requester ack handling, transmitter model.
    task automatic tick();
        logic [7:0] eb;
        int g, got;
        @(negedge clock);
        if (tx_start === 1'b1) begin
            n_starts++;
            checks++;
            if (exp_bytes.size() == 0) begin
                errors++;
                $display("FAIL tx_byte: got tx_start with data %h, no byte expected", tx_data);
            end else begin
                eb = exp_bytes.pop_front();
                if (tx_data !== eb) begin
                    errors++;
                    $display("FAIL tx_byte: got %h, expected %h", tx_data, eb);
                end
            end
        end
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            checks++;
            got = (ack1 === 1'b1) ? 1 : 0;
            if (ack0 === 1'b1 && ack1 === 1'b1) begin
                errors++;
                $display("FAIL ack_grant: ack0 and ack1 both high, expected one");
            end else if (exp_grants.size() == 0) begin
                errors++;
                $display("FAIL ack_grant: got ack%0d, expected no ack", got);
            end else begin
                g = exp_grants.pop_front();
                if (got != g) begin
                    errors++;
                    $display("FAIL ack_grant: got ack%0d, expected ack%0d", got, g);
                end
            end
            checks++;
            if ((ack0 === 1'b1 && prev_ack0 === 1'b1) || (ack1 === 1'b1 && prev_ack1 === 1'b1)) begin
                errors++;
                $display("FAIL ack_pulse: ack high 2 cycles, expected 1");
            end
        end
        prev_ack0 = ack0;
        prev_ack1 = ack1;
        if (ack0 === 1'b1) begin
            req0 = 1'b0;
            n_ack0++;
        end
        if (ack1 === 1'b1) req1 = 1'b0;
        // Transmitter: busy (tx_done low) for 20 cycles per byte unless stuck.
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end else if (tx_start === 1'b1 && !tx_stuck) begin
            tx_done = 1'b0;
            tx_cnt  = 20;
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while ((exp_bytes.size() != 0 || exp_grants.size() != 0 || busy !== 1'b0) && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (exp_bytes.size() != 0 || exp_grants.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: timeout, got %0d bytes %0d grants pending busy=%b, expected none",
                     name, exp_bytes.size(), exp_grants.size(), busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({ack0, ack1, tx_start, busy, err, tx_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero", {ack0, ack1, tx_start, busy, err, tx_data});
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b tx_start=%b, expected 0 0", busy, tx_start);
        end
    endtask

    task automatic test_single_word();
        int k;
        exp_grants.push_back(0);
        push_word(32'hA1B2C3D4);
        word0 = 32'hA1B2C3D4;
        req0  = 1'b1;
        tick();
        checks++;
        if (ack0 !== 1'b1 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL grant_latency: got ack0=%b tx_start=%b, expected 1 1", ack0, tx_start);
        end
        k = 0;
        while (exp_bytes.size() != 0 && k < 200) begin tick(); k++; end
        k = 0;
        while (tx_done !== 1'b1 && k < 40) begin tick(); k++; end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_last_done: got busy=%b at final tx_done, expected 1", busy);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: got busy=%b two cycles after final tx_done, expected 0", busy);
        end
        wait_idle(100, "single_word");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL single_err: got err=%b, expected 0", err);
        end
    endtask

    task automatic test_tie_alternate();
        int rem0 = 1, rem1 = 1, k = 0;
        do_reset();
        exp_grants.push_back(0); exp_grants.push_back(1);
        exp_grants.push_back(0); exp_grants.push_back(1);
        push_word(32'h10203040); push_word(32'h50607080);
        push_word(32'h90A0B0C0); push_word(32'hD0E0F001);
        word0 = 32'h10203040; word1 = 32'h50607080;
        req0 = 1'b1; req1 = 1'b1;
        while ((exp_bytes.size() != 0 || exp_grants.size() != 0 || busy !== 1'b0 || rem0 > 0 || rem1 > 0) && k < 2000) begin
            tick();
            k++;
            if (req0 === 1'b0 && rem0 > 0) begin word0 = 32'h90A0B0C0; req0 = 1'b1; rem0--; end
            if (req1 === 1'b0 && rem1 > 0) begin word1 = 32'hD0E0F001; req1 = 1'b1; rem1--; end
        end
        checks++;
        if (exp_bytes.size() != 0 || exp_grants.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_alternate: timeout, got %0d bytes %0d grants pending, expected none",
                     exp_bytes.size(), exp_grants.size());
        end
    endtask

    task automatic test_late_req1();
        int base = n_starts, k = 0, exp_n;
        bit seen = 0;
        exp_grants.push_back(0);
        push_word(32'h0F1E2D3C);
        word0 = 32'h0F1E2D3C;
        req0  = 1'b1;
        while (n_starts < base + 3 && k < 300) begin tick(); k++; end
        exp_grants.push_back(1);
        push_word(32'h4B5A6978);
        word1 = 32'h4B5A6978;
        req1  = 1'b1;
        // word0's four bytes, plus word1's first byte which starts in the ack cycle
        exp_n = base + 5;
        k = 0;
        while (!seen && k < 300) begin
            tick();
            k++;
            if (ack1 === 1'b1) begin
                seen = 1;
                checks++;
                if (n_starts != exp_n) begin
                    errors++;
                    $display("FAIL late_ack1: got %0d tx_starts at ack1, expected %0d", n_starts - base, exp_n - base);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL late_ack1_seen: got no ack1, expected one");
        end
        wait_idle(300, "late_req1");
    endtask

    task automatic test_timeout();
        int k = 0;
        tx_stuck = 1;
        exp_grants.push_back(0);
        exp_bytes.push_back(8'h11);
        word0 = 32'h44332211;
        req0  = 1'b1;
        while (tx_start !== 1'b1 && k < 10) begin tick(); k++; end
        k = 0;
        while (err !== 1'b1 && k < 40) begin tick(); k++; end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL timeout_len: got err %0d cycles after tx_start, expected 16", k);
        end
        checks++;
        if (busy !== 1'b0 || exp_bytes.size() != 0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b pending=%0d, expected 0 0", busy, exp_bytes.size());
        end
        tx_stuck = 0;
        tick();
        exp_grants.push_back(0);
        push_word(32'h87654321);
        word0 = 32'h87654321;
        req0  = 1'b1;
        wait_idle(200, "after_timeout");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got err=%b, expected 1", err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = n_starts, k = 0;
        exp_grants.push_back(0);
        exp_bytes.push_back(8'h88);
        exp_bytes.push_back(8'h77);
        word0 = 32'h55667788;
        req0  = 1'b1;
        while (n_starts < base + 2 && k < 100) begin tick(); k++; end
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_start, busy, ack0, ack1, err} !== 5'd0) begin
            errors++;
            $display("FAIL reset_async: got tx_start,busy,ack0,ack1,err=%b, expected 00000",
                     {tx_start, busy, ack0, ack1, err});
        end
        tick();
        reset = 1'b0;
        k = 0;
        while (tx_cnt != 0 && k < 40) begin tick(); k++; end
        tick();
        checks++;
        if (exp_bytes.size() != 0 || exp_grants.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d bytes pending busy=%b, expected 0 0", exp_bytes.size(), busy);
        end
        exp_grants.push_back(0);
        push_word(32'h0A0B0C0D);
        word0 = 32'h0A0B0C0D;
        req0  = 1'b1;
        wait_idle(200, "after_reset");
    endtask

    task automatic test_drop_req();
        int base = n_starts, a0 = n_ack0, k = 0;
        exp_grants.push_back(1);
        push_word(32'h99AABBCC);
        word1 = 32'h99AABBCC;
        req1  = 1'b1;
        while (n_starts < base + 1 && k < 20) begin tick(); k++; end
        word0 = 32'hDEADBEEF;
        req0  = 1'b1;
        repeat (3) tick();
        req0 = 1'b0;
        wait_idle(200, "drop_req");
        repeat (10) tick();
        checks++;
        if (n_ack0 != a0 || n_starts != base + 4) begin
            errors++;
            $display("FAIL dropped_req: got %0d ack0 and %0d tx_starts, expected 0 and 4",
                     n_ack0 - a0, n_starts - base);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        word0 = '0; word1 = '0;
        tx_done = 1'b1;
        test_reset();
        test_single_word();
        test_tie_alternate();
        test_late_req1();
        test_timeout();
        test_reset_mid_frame();
        test_drop_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_word_arbiter.md
Name: tx_word_arbiter

Overview:
Shares the single UART transmitter between two requesters, e.g. the debug unit's register-dump and PC/status reporting paths. Each requester hands over a full word; the block arbitrates round-robin, splits the word into bytes (LSB first) and sequences the transmitter one byte at a time. It uses the transmitter's tx_start / tx_done handshake and includes a watchdog for the case where the transmitter never responds.

Parameters:
N_BITS_DATA, 8, byte width driven to the transmitter.
N_BYTES, 4, bytes per word; the word width is N_BITS_DATA*N_BYTES.
N_BITS_TOUT, 4, width of the watchdog counter.
TOUT_CYCLES, 15, maximum cycles to wait for the transmitter to go busy after tx_start.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
req0  in  1  requester 0 has a word pending; held high until ack0.
word0  in  N_BITS_DATA*N_BYTES  requester 0 word; must be stable while req0 is high.
ack0  out  1  one-cycle pulse: word0 has been latched.
req1  in  1  requester 1 has a word pending.
word1  in  N_BITS_DATA*N_BYTES  requester 1 word.
ack1  out  1  one-cycle pulse: word1 has been latched.
tx_done  in  1  transmitter done/idle indication; low while a frame is in flight.
tx_start  out  1  one-cycle start strobe to the transmitter.
tx_data  out  N_BITS_DATA  byte presented to the transmitter; valid while tx_start is high.
busy  out  1  high whenever state is not IDLE.
err  out  1  sticky watchdog error; cleared only by reset.

Behaviour:
- All outputs are registered. Reset (asynchronous, active-high) forces state IDLE and clears every output, the byte index, the watchdog counter and the last-grant pointer (points to requester 1, so requester 0 wins the first tie). Assertion mid-frame drops tx_start immediately and abandons the current word; no ack is reissued.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT.
- IDLE: if any req is high, grant one.
  - A single request wins directly.
  - If both are high, grant the requester that is not last_grant.
  - At that edge: latch the word into the shift register, set byte index 0, pulse ackN high for exactly the next cycle, update last_grant, and go to START.
  - A request dropped before the grant edge is ignored.
- START: tx_start=1 for exactly one cycle; tx_data = latched word bits [N_BITS_DATA-1:0]. Clear the watchdog, then go to WAIT_BUSY.
- WAIT_BUSY: tx_start=0; tx_data holds its value.
  - tx_done==0: go to WAIT_DONE.
  - Otherwise increment the watchdog; if it reaches TOUT_CYCLES, set err and go to IDLE, discarding the remaining bytes.
- WAIT_DONE: stay until tx_done==1, then go to NEXT. This state has no timeout, because the frame length is set by baud rate.
- NEXT: shift the word right by N_BITS_DATA and increment the byte index.
  - If the index was N_BYTES-1, go to IDLE.
  - Otherwise go to START.
- Latency:
  - req high at IDLE edge n gives ack and START at cycle n+1.
  - tx_start is high in cycle n+1.
  - Minimum gap between consecutive tx_start pulses is 4 cycles plus the frame time.
- Requests arriving while busy stay pending and are arbitrated on the next IDLE. A requester re-raising req on the cycle after ack is legal.
- The byte index must not wrap. N_BYTES=1 is supported (NEXT goes straight to IDLE).
- err does not block further operation; subsequent words are still sent.

Test Plan:
- Reset, then req0 with word0=0xA1B2C3D4 and a model transmitter (busy 20 cycles per byte) → ack0 one cycle; four tx_start pulses with tx_data 0xD4, 0xC3, 0xB2, 0xA1; busy falls after the last tx_done; err stays 0.
- req0 and req1 both raised in the same cycle from reset, held until acked → requester 0 is served first (all 4 bytes), then requester 1; with both re-raised after service, grants alternate 1, 0, 1.
- req1 raised while requester 0's word is in byte 2 → ack1 only after the byte-3 tx_done, and no interleaving of bytes.
- Transmitter model holds tx_done=1 permanently → after tx_start, err sets after 15 WAIT_BUSY cycles; block returns to IDLE; the next word is still attempted.
- Reset asserted asynchronously mid-WAIT_DONE on byte 1 → tx_start, busy, ack0/1 and err are 0 immediately; a new req0 restarts from byte 0 of the new word.
- req0 pulsed high for part of a busy period and dropped before IDLE → no ack0 and no transmission.
